rst_sequencer: RTL and testbench

Staged reset distributor that sits downstream of the board-level reset synchronizer and drives the per-subsystem active-low resets. It holds every domain in reset for a fixed interval, then releases the domains one at a time in index order, with a fixed gap between releases. It also accepts a one-cycle soft-reset request from the command path and replays the same sequence. A one-cycle done pulse marks the end of each sequence.

---
 rtl/rst_sequencer.sv | 59 +++++
 tb/tb_rst_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// rst_sequencer: staged per-domain reset release after a common hold interval,
// with soft-reset replay and a one-cycle done pulse; all state on negedge clk.
module rst_sequencer #(
   parameter int NUM_DOM   = 3,
   parameter int HOLD_CYC  = 16,
   parameter int STAGE_CYC = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               soft_rst_req,
   output logic [NUM_DOM-1:0] dom_rst_n,
   output logic               busy,
   output logic               seq_done
);
   localparam int MAXC = HOLD_CYC > STAGE_CYC ? HOLD_CYC : STAGE_CYC;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int IW   = $clog2(NUM_DOM + 1);
   typedef enum logic [1:0] {ASSERT, RELEASE, IDLE} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic          last;
   logic          done;
   assign last = idx == IW'(NUM_DOM - 1);
   // completion is independent of soft_rst_req so a colliding request still sees the pulse
   assign done = cnt == CW'(1) && (state == ASSERT ? NUM_DOM == 1 : state == RELEASE && last);
   always_ff @(negedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= ASSERT;
         cnt       <= CW'(HOLD_CYC);
         idx       <= '0;
         dom_rst_n <= '0;
         busy      <= 1'b1;
         seq_done  <= 1'b0;
      end else begin
         seq_done <= done;
         if (soft_rst_req) begin
            state     <= ASSERT;
            cnt       <= CW'(HOLD_CYC);
            idx       <= '0;
            dom_rst_n <= '0;
            busy      <= 1'b1;
         end else if (state != IDLE) begin
            if (cnt != CW'(1)) cnt <= cnt - 1'b1;
            else begin
               dom_rst_n <= dom_rst_n | (NUM_DOM'(1) << idx);
               if (done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  state <= RELEASE;
                  idx   <= idx + 1'b1;
                  cnt   <= CW'(STAGE_CYC);
               end
            end
         end
      end
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed checks of the default sequencer plus two parameter variants.
module tb_rst_sequencer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       soft_rst_req = 1'b0;
   logic       soft1 = 1'b0;
   logic       soft4 = 1'b0;
   logic [2:0] dom;
   logic [0:0] dom1;
   logic [3:0] dom4;
   logic       busy, busy1, busy4;
   logic       done, done1, done4;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   rst_sequencer dut (.clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req),
      .dom_rst_n(dom), .busy(busy), .seq_done(done));
   rst_sequencer #(.NUM_DOM(1), .HOLD_CYC(1), .STAGE_CYC(1)) dut1 (.clk(clk), .rst_n(rst_n),
      .soft_rst_req(soft1), .dom_rst_n(dom1), .busy(busy1), .seq_done(done1));
   rst_sequencer #(.NUM_DOM(4), .HOLD_CYC(3), .STAGE_CYC(1)) dut4 (.clk(clk), .rst_n(rst_n),
      .soft_rst_req(soft4), .dom_rst_n(dom4), .busy(busy4), .seq_done(done4));

   // expected default-parameter domain pattern r edges after sequence start
   function automatic logic [2:0] dexp(int r);
      return r < 16 ? 3'b000 : r < 24 ? 3'b001 : r < 32 ? 3'b011 : 3'b111;
   endfunction

   // lands half a cycle after the negedge the DUT acts on
   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      soft_rst_req = 1'b1;
      repeat (3) adv();
      checks++; if (dom !== 3'b000) begin failures++; $display("FAIL rst_dom got=%b exp=000", dom); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
      checks++; if (dom4 !== 4'b0000 || busy4 !== 1'b1) begin failures++; $display("FAIL rst_dut4 got=%b/%b exp=0000/1", dom4, busy4); end
      soft_rst_req = 1'b0;
   endtask

   task automatic test_power_on();
      int pulses = 0;
      rst_n = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         adv();
         pulses += int'(done);
         checks++; if (dom !== dexp(e)) begin failures++; $display("FAIL pwr_dom edge=%0d got=%b exp=%b", e, dom, dexp(e)); end
         checks++; if (busy !== (e < 32)) begin failures++; $display("FAIL pwr_busy edge=%0d got=%b exp=%b", e, busy, e < 32); end
         checks++; if (done !== (e == 32)) begin failures++; $display("FAIL pwr_done edge=%0d got=%b exp=%b", e, done, e == 32); end
      end
      checks++; if (pulses != 1) begin failures++; $display("FAIL pwr_pulses got=%0d exp=1", pulses); end
   endtask

   task automatic test_soft_idle();
      int pulses = 0;
      soft_rst_req = 1'b1;
      adv();
      soft_rst_req = 1'b0;
      checks++; if (dom !== 3'b000 || busy !== 1'b1) begin failures++; $display("FAIL idle_req dom/busy got=%b/%b exp=000/1", dom, busy); end
      for (int r = 1; r <= 40; r++) begin
         adv();
         pulses += int'(done);
         checks++; if (dom !== dexp(r)) begin failures++; $display("FAIL idle_dom rel=%0d got=%b exp=%b", r, dom, dexp(r)); end
         checks++; if (busy !== (r < 32)) begin failures++; $display("FAIL idle_busy rel=%0d got=%b exp=%b", r, busy, r < 32); end
      end
      checks++; if (pulses != 1) begin failures++; $display("FAIL idle_pulses got=%0d exp=1", pulses); end
   endtask

   task automatic test_soft_mid();
      soft_rst_req = 1'b1;
      adv();
      soft_rst_req = 1'b0;
      repeat (25) adv();
      checks++; if (dom !== 3'b011) begin failures++; $display("FAIL mid_pre got=%b exp=011", dom); end
      soft_rst_req = 1'b1;
      adv();
      soft_rst_req = 1'b0;
      checks++; if (dom !== 3'b000 || busy !== 1'b1) begin failures++; $display("FAIL mid_abort dom/busy got=%b/%b exp=000/1", dom, busy); end
      for (int r = 1; r <= 34; r++) begin
         adv();
         checks++; if (dom !== dexp(r)) begin failures++; $display("FAIL mid_dom rel=%0d got=%b exp=%b", r, dom, dexp(r)); end
         checks++; if (done !== (r == 32)) begin failures++; $display("FAIL mid_done rel=%0d got=%b exp=%b", r, done, r == 32); end
      end
   endtask

   task automatic test_async();
      rst_n = 1'b0;
      adv();
      rst_n = 1'b1;
      repeat (20) adv();
      checks++; if (dom !== 3'b001) begin failures++; $display("FAIL async_pre got=%b exp=001", dom); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (dom !== 3'b000 || busy !== 1'b1) begin failures++; $display("FAIL async_now dom/busy got=%b/%b exp=000/1", dom, busy); end
      adv();
      rst_n = 1'b1;
      for (int e = 1; e <= 34; e++) begin
         adv();
         checks++; if (dom !== dexp(e)) begin failures++; $display("FAIL async_dom edge=%0d got=%b exp=%b", e, dom, dexp(e)); end
         checks++; if (done !== (e == 32)) begin failures++; $display("FAIL async_done edge=%0d got=%b exp=%b", e, done, e == 32); end
      end
   endtask

   task automatic test_collision();
      soft_rst_req = 1'b1;
      adv();
      soft_rst_req = 1'b0;
      repeat (31) adv();
      soft_rst_req = 1'b1;
      adv();
      soft_rst_req = 1'b0;
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL coll_done got=%b exp=1", done); end
      checks++; if (dom !== 3'b000 || busy !== 1'b1) begin failures++; $display("FAIL coll_dom dom/busy got=%b/%b exp=000/1", dom, busy); end
      for (int r = 1; r <= 34; r++) begin
         adv();
         checks++; if (dom !== dexp(r)) begin failures++; $display("FAIL coll_dom rel=%0d got=%b exp=%b", r, dom, dexp(r)); end
         checks++; if (done !== (r == 32)) begin failures++; $display("FAIL coll_seq rel=%0d got=%b exp=%b", r, done, r == 32); end
      end
   endtask

   task automatic test_sweep();
      logic [3:0] d4;
      rst_n = 1'b0;
      adv();
      checks++; if (dom1 !== 1'b0 || busy1 !== 1'b1) begin failures++; $display("FAIL sw1_rst got=%b/%b exp=0/1", dom1, busy1); end
      rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         adv();
         d4 = e < 3 ? 4'b0000 : e == 3 ? 4'b0001 : e == 4 ? 4'b0011 : e == 5 ? 4'b0111 : 4'b1111;
         checks++; if (dom1 !== 1'b1) begin failures++; $display("FAIL sw1_dom edge=%0d got=%b exp=1", e, dom1); end
         checks++; if (done1 !== (e == 1) || busy1 !== 1'b0) begin failures++; $display("FAIL sw1_done edge=%0d got=%b/%b exp=%b/0", e, done1, busy1, e == 1); end
         checks++; if (dom4 !== d4) begin failures++; $display("FAIL sw4_dom edge=%0d got=%b exp=%b", e, dom4, d4); end
         checks++; if (done4 !== (e == 6) || busy4 !== (e < 6)) begin failures++; $display("FAIL sw4_done edge=%0d got=%b/%b exp=%b/%b", e, done4, busy4, e == 6, e < 6); end
      end
   endtask

   initial begin
      test_reset();
      test_power_on();
      test_soft_idle();
      test_soft_mid();
      test_async();
      test_collision();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
